// File: rtl/cnn_pkg.sv
// cnn_pkg: shared dimensions of the first CNN block (conv1 output feeding pool1)
package cnn_pkg;
  localparam int CONV1_OUT_W = 24;
  localparam int CONV1_OUT_H = 24;
  localparam int FEAT_W      = 12;
  localparam int POOL1_OUT_W = 12;
  localparam int NUM_CH1     = 3;
endpackage

// File: rtl/pool1_relu_maxpool_relu_max2.sv
// relu_max2: ReLU on a new sample followed by an unsigned max against a stored value
//   sample_i : raw signed sample
//   stored_i : already non-negative comparison value
//   max_o    : max(relu(sample_i), stored_i)
module relu_max2 import cnn_pkg::*; #(
  parameter int DATA_W = FEAT_W
) (
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] stored_i,
  output logic [DATA_W-1:0] max_o
);
  logic [DATA_W-1:0] relu;
  assign relu  = sample_i[DATA_W-1] ? '0 : sample_i;
  assign max_o = relu > stored_i ? relu : stored_i;
endmodule

// File: rtl/pool1_relu_maxpool.sv
// pool1_relu_maxpool: ReLU + 2x2/stride-2 max pooling of the 3-channel conv1 raster stream
//   gclk, rst_n          : gated clock, async active-low reset
//   valid_in, conv_in_*  : one signed pixel triplet per strobe, raster order
//   valid_out, pool_out_*: one pooled non-negative triplet per strobe
//   busy                 : high from the first pixel until the last window is emitted
module pool1_relu_maxpool import cnn_pkg::*; #(
  parameter int IN_WIDTH  = CONV1_OUT_W,
  parameter int IN_HEIGHT = CONV1_OUT_H,
  parameter int DATA_W    = FEAT_W
) (
  input  logic              gclk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] conv_in_1,
  input  logic [DATA_W-1:0] conv_in_2,
  input  logic [DATA_W-1:0] conv_in_3,
  output logic [DATA_W-1:0] pool_out_1,
  output logic [DATA_W-1:0] pool_out_2,
  output logic [DATA_W-1:0] pool_out_3,
  output logic              valid_out,
  output logic              busy
);
  localparam int XW = $clog2(IN_WIDTH);
  localparam int YW = $clog2(IN_HEIGHT);
  typedef logic [NUM_CH1-1:0][DATA_W-1:0] trip_t;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  trip_t in_c, h_stored, hmax_c, vmax_c, rd_c, h_hold_q, h_hold_d, pool_q, pool_d;
  trip_t row_buf_q [IN_WIDTH/2];
  logic valid_out_q, valid_out_d, busy_q, busy_d, x_last, y_last;
  logic [XW-2:0] col;
  assign in_c   = {conv_in_3, conv_in_2, conv_in_1};
  assign x_last = x_q == XW'(IN_WIDTH - 1);
  assign y_last = y_q == YW'(IN_HEIGHT - 1);
  assign col    = x_q[XW-1:1];
  assign rd_c   = row_buf_q[col];
  for (genvar c = 0; c < NUM_CH1; c++) begin : g_ch
    // On even columns the stored side is zero, so hmax is just the ReLU'd sample to latch.
    assign h_stored[c] = x_q[0] ? h_hold_q[c] : '0;
    relu_max2 #(.DATA_W(DATA_W)) u_h (.sample_i(in_c[c]), .stored_i(h_stored[c]), .max_o(hmax_c[c]));
    relu_max2 #(.DATA_W(DATA_W)) u_v (.sample_i(hmax_c[c]), .stored_i(rd_c[c]), .max_o(vmax_c[c]));
  end
  always_comb begin
    x_d         = valid_in ? (x_last ? '0 : x_q + 1'b1) : x_q;
    y_d         = valid_in && x_last ? (y_last ? '0 : y_q + 1'b1) : y_q;
    h_hold_d    = valid_in && !x_q[0] ? hmax_c : h_hold_q;
    valid_out_d = valid_in && x_q[0] && y_q[0];
    pool_d      = valid_out_d ? vmax_c : pool_q;
    busy_d      = !valid_in ? busy_q : (x_last && y_last) ? 1'b0 : (x_q == '0 && y_q == '0) ? 1'b1 : busy_q;
  end
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      h_hold_q    <= '0;
      pool_q      <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      h_hold_q    <= h_hold_d;
      pool_q      <= pool_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
    end
  end
  // Row buffer is not reset: every even row rewrites it before the odd row reads it.
  always_ff @(posedge gclk) begin
    if (rst_n && valid_in && x_q[0] && !y_q[0]) row_buf_q[col] <= hmax_c;
  end
  assign pool_out_1 = pool_q[0];
  assign pool_out_2 = pool_q[1];
  assign pool_out_3 = pool_q[2];
  assign valid_out  = valid_out_q;
  assign busy       = busy_q;
endmodule
